// File: rtl/user_irq_ctrl_pkg.sv
// Shared constants for the user interrupt controller: register map, field widths,
// reset values and the Wishbone byte-lane merge helper.
package user_irq_ctrl_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned ROUTE_W = 2;
  localparam int unsigned COUNT_W = 16;

  localparam logic [7:0] OFS_ENABLE   = 8'h00;
  localparam logic [7:0] OFS_MODE     = 8'h04;
  localparam logic [7:0] OFS_POLARITY = 8'h08;
  localparam logic [7:0] OFS_PENDING  = 8'h0C;
  localparam logic [7:0] OFS_ROUTE    = 8'h10;
  localparam logic [7:0] OFS_COUNT    = 8'h14;

  localparam logic [WB_DW-1:0] ENABLE_RST   = 32'h0000_0000;
  localparam logic [WB_DW-1:0] MODE_RST     = 32'h0000_0000;
  localparam logic [WB_DW-1:0] POL_RST      = 32'hFFFF_FFFF;
  localparam logic [WB_DW-1:0] PENDING_RST  = 32'h0000_0000;
  localparam logic [WB_DW-1:0] ROUTE_RST    = 32'h0000_0000;

  // Replace the byte lanes of old_val selected by sel with the matching lanes of new_val.
  function automatic logic [WB_DW-1:0] apply_sel(input logic [WB_DW-1:0] old_val,
                                                 input logic [WB_DW-1:0] new_val,
                                                 input logic [SEL_W-1:0] sel);
    logic [WB_DW-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_irq_ctrl_if.sv
// Wishbone slave bus bundle between the management core and the interrupt controller.
interface user_irq_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_irq_ctrl_sync.sv
// Per-source two-flop synchroniser with polarity qualification and active-edge detect.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic pol,
  output logic act_c,
  output logic rise_c
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Both taps use the current polarity, so a polarity change alone never fakes an edge.
  assign act_c  = ~(sync2 ^ pol);
  assign rise_c = act_c & (sync3 ^ pol);

endmodule

// File: rtl/user_irq_ctrl.sv
// Wishbone-mapped user interrupt controller: enable/mode/polarity/pending/route per source.
// Define USER_IRQ_CTRL_COUNT_EN to add the saturating pending-rise counter at 0x14.
module user_irq_ctrl
  import user_irq_ctrl_pkg::*;
#(
  parameter int unsigned NSRC     = 8,
  parameter int unsigned NIRQ     = 3,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  user_irq_ctrl_if.slave      wbs,
  input  logic [NSRC-1:0]     src_i,
  output logic [NIRQ-1:0]     irq_o
);

  localparam int unsigned RW = ROUTE_W * NSRC;

  logic [NSRC-1:0]  en_q, mode_q, pol_q, pend_q;
  logic [RW-1:0]    route_q;
  logic [NIRQ-1:0]  irq_q;
  logic             ack_q;
  logic [WB_DW-1:0] dat_q;

  logic [NSRC-1:0]  act_c, rise_c, clr_c, pend_nxt_c;
  logic [NIRQ-1:0]  irq_nxt_c;
  logic             hit_c, wr_c;
  logic [7:0]       ofs_c;
  logic [WB_DW-1:0] rdata_c;
  logic             unused_c;

  for (genvar i = 0; i < int'(NSRC); i++) begin : g_src
    irq_sync_edge u_sync (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .src    (src_i[i]),
      .pol    (pol_q[i]),
      .act_c  (act_c[i]),
      .rise_c (rise_c[i])
    );
  end

  // A new access is accepted only when ack is low, so a held strobe never gets a second ack in a row.
  assign hit_c    = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q &
                    (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign wr_c     = hit_c & wbs.wbs_we_i;
  assign ofs_c    = {wbs.wbs_adr_i[7:2], 2'b00};
  assign unused_c = ^wbs.wbs_adr_i[1:0];

  assign clr_c = (wr_c && ofs_c == OFS_PENDING)
               ? NSRC'(apply_sel('0, wbs.wbs_dat_i, wbs.wbs_sel_i)) : '0;

  // Edge sources latch (set beats W1C); level sources simply follow the qualified input.
  assign pend_nxt_c = (mode_q & ((pend_q & ~clr_c) | (rise_c & en_q)))
                    | (~mode_q & act_c & en_q);

  always_comb begin
    irq_nxt_c = '0;
    for (int unsigned k = 0; k < NIRQ; k++) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (route_q[ROUTE_W*i +: ROUTE_W] == ROUTE_W'(k))
          irq_nxt_c[k] = irq_nxt_c[k] | (pend_q[i] & en_q[i]);
      end
    end
  end

`ifdef USER_IRQ_CTRL_COUNT_EN
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W:0]   count_sum_c;

  always_comb begin
    count_sum_c = {1'b0, count_q};
    for (int unsigned i = 0; i < NSRC; i++)
      count_sum_c = count_sum_c + (COUNT_W+1)'(pend_nxt_c[i] & ~pend_q[i]);
  end

  // Saturating count of pending rises; any write to the counter clears it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                         count_q <= '0;
    else if (wr_c && ofs_c == OFS_COUNT)  count_q <= '0;
    else if (count_sum_c[COUNT_W])        count_q <= '1;
    else                                  count_q <= count_sum_c[COUNT_W-1:0];
  end
`endif

  always_comb begin
    rdata_c = '0;
    case (ofs_c)
      OFS_ENABLE:   rdata_c = WB_DW'(en_q);
      OFS_MODE:     rdata_c = WB_DW'(mode_q);
      OFS_POLARITY: rdata_c = WB_DW'(pol_q);
      OFS_PENDING:  rdata_c = WB_DW'(pend_q);
      OFS_ROUTE:    rdata_c = WB_DW'(route_q);
`ifdef USER_IRQ_CTRL_COUNT_EN
      OFS_COUNT:    rdata_c = WB_DW'(count_q);
`endif
      default:      rdata_c = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en_q    <= NSRC'(ENABLE_RST);
      mode_q  <= NSRC'(MODE_RST);
      pol_q   <= NSRC'(POL_RST);
      pend_q  <= NSRC'(PENDING_RST);
      route_q <= RW'(ROUTE_RST);
      irq_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ack_q  <= hit_c;
      dat_q  <= hit_c ? rdata_c : '0;
      pend_q <= pend_nxt_c;
      irq_q  <= irq_nxt_c;
      if (wr_c) begin
        case (ofs_c)
          OFS_ENABLE:   en_q    <= NSRC'(apply_sel(WB_DW'(en_q),    wbs.wbs_dat_i, wbs.wbs_sel_i));
          OFS_MODE:     mode_q  <= NSRC'(apply_sel(WB_DW'(mode_q),  wbs.wbs_dat_i, wbs.wbs_sel_i));
          OFS_POLARITY: pol_q   <= NSRC'(apply_sel(WB_DW'(pol_q),   wbs.wbs_dat_i, wbs.wbs_sel_i));
          OFS_ROUTE:    route_q <= RW'(apply_sel(WB_DW'(route_q),   wbs.wbs_dat_i, wbs.wbs_sel_i));
          default: ;
        endcase
      end
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_user_irq_ctrl.sv
// Self-checking bench for user_irq_ctrl: directed scenarios plus randomized traffic vs. a reference model.
module tb_user_irq_ctrl;
  import user_irq_ctrl_pkg::*;

  localparam int unsigned NSRC = 8;
  localparam int unsigned NIRQ = 3;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] src = '0;
  logic [NIRQ-1:0] irq;
  int              n_chk = 0;
  int              n_fail = 0;

  user_irq_ctrl_if bus ();

  user_irq_ctrl #(.NSRC(NSRC), .NIRQ(NIRQ), .BASE_ADR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .src_i    (src),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ra(input logic [7:0] ofs);
    return BASE | 32'(ofs);
  endfunction

  // Expected irq lines from the routing rule: an enabled pending source drives the line its ROUTE names.
  function automatic logic [NIRQ-1:0] irq_of(input logic [NSRC-1:0] pend, input logic [NSRC-1:0] en,
                                             input logic [2*NSRC-1:0] route);
    logic [NIRQ-1:0] m;
    int r;
    m = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      r = int'(route[2*i +: 2]);
      if (pend[i] && en[i] && r < int'(NIRQ)) m[r] = 1'b1;
    end
    return m;
  endfunction

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rd, output logic acked,
                           output int lat);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = wd;
    acked = 1'b0; rd = '0; lat = 0;
    for (int c = 1; c <= 16 && !acked; c++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin acked = 1'b1; rd = bus.wbs_dat_o; lat = c; end
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic wb_wr(input logic [7:0] ofs, input logic [31:0] d);
    logic [31:0] rd; logic ok; int lat;
    wb_access(ra(ofs), 1'b1, d, 4'hF, rd, ok, lat);
  endtask

  task automatic wb_rd(input logic [7:0] ofs, output logic [31:0] d, output logic ok);
    int lat;
    wb_access(ra(ofs), 1'b0, '0, 4'hF, d, ok, lat);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic ok;
    do_reset();
    n_chk++; if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.wbs_ack_o); end
    n_chk++; if (bus.wbs_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", bus.wbs_dat_o); end
    n_chk++; if (irq !== 3'b000) begin n_fail++; $display("FAIL reset_irq: got %b want 000", irq); end
    wb_rd(OFS_POLARITY, d, ok);
    n_chk++; if (!ok || d !== 32'h0000_00FF) begin n_fail++; $display("FAIL reset_pol: got %h ack %b want 000000ff", d, ok); end
    wb_rd(OFS_ENABLE, d, ok);
    n_chk++; if (!ok || d !== 32'h0) begin n_fail++; $display("FAIL reset_enable: got %h ack %b want 0", d, ok); end
  endtask

  task automatic test_edge();
    logic [31:0] d; logic ok;
    do_reset();
    src = '0;
    wb_wr(OFS_ROUTE, 32'h0);
    wb_wr(OFS_MODE, 32'h1);
    wb_wr(OFS_ENABLE, 32'h1);
    src[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (irq !== 3'b000) begin n_fail++; $display("FAIL edge_3rd: got %b want 000", irq); end
    @(posedge clk); #1;
    n_chk++; if (irq !== 3'b001) begin n_fail++; $display("FAIL edge_4th: got %b want 001", irq); end
    wb_rd(OFS_PENDING, d, ok);
    n_chk++; if (!ok || d !== 32'h1) begin n_fail++; $display("FAIL edge_pending: got %h want 1", d); end
    wb_wr(OFS_PENDING, 32'h1);
    @(posedge clk); #1;
    n_chk++; if (irq !== 3'b000) begin n_fail++; $display("FAIL edge_w1c_irq: got %b want 000", irq); end
    wb_rd(OFS_PENDING, d, ok);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_w1c_pend: got %h want 0", d); end
    // Edge while disabled is lost.
    wb_wr(OFS_ENABLE, 32'h0);
    src[0] = 1'b0; repeat (4) @(negedge clk);
    src[0] = 1'b1; repeat (5) @(negedge clk);
    wb_wr(OFS_ENABLE, 32'h1);
    wb_rd(OFS_PENDING, d, ok);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_disabled_lost: got %h want 0", d); end
  endtask

  task automatic test_level();
    do_reset();
    src = 8'hFF;
    wb_wr(OFS_POLARITY, 32'h7F);
    wb_wr(OFS_ROUTE, 32'h0000_8000);
    wb_wr(OFS_ENABLE, 32'h80);
    n_chk++; if (irq !== 3'b000) begin n_fail++; $display("FAIL level_idle: got %b want 000", irq); end
    src[7] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (irq !== 3'b000) begin n_fail++; $display("FAIL level_3rd: got %b want 000", irq); end
    @(posedge clk); #1;
    n_chk++; if (irq !== 3'b100) begin n_fail++; $display("FAIL level_assert: got %b want 100", irq); end
    wb_wr(OFS_PENDING, 32'h80);
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (irq !== 3'b100) begin n_fail++; $display("FAIL level_w1c_no_effect: got %b want 100", irq); end
    @(negedge clk);
    src[7] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (irq !== 3'b000) begin n_fail++; $display("FAIL level_release: got %b want 000", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic ok;
    do_reset();
    src = '0;
    wb_wr(OFS_MODE, 32'h08);
    wb_wr(OFS_ENABLE, 32'h08);
    src[3] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = ra(OFS_PENDING); bus.wbs_dat_i = 32'h08;
    @(posedge clk); #1;
    n_chk++; if (bus.wbs_ack_o !== 1'b1) begin n_fail++; $display("FAIL coll_ack: got %b want 1", bus.wbs_ack_o); end
    @(negedge clk);
    bus_idle();
    @(posedge clk); #1;
    n_chk++; if (irq !== 3'b001) begin n_fail++; $display("FAIL coll_irq: got %b want 001", irq); end
    wb_rd(OFS_PENDING, d, ok);
    n_chk++; if (d !== 32'h08) begin n_fail++; $display("FAIL coll_pending: got %h want 08", d); end
    n_chk++; if (irq !== 3'b001) begin n_fail++; $display("FAIL coll_irq_held: got %b want 001", irq); end
  endtask

  task automatic test_bus();
    logic [31:0] d; logic ok; int lat;
    do_reset();
    wb_access(ra(8'h20), 1'b0, '0, 4'hF, d, ok, lat);
    n_chk++; if (!ok || lat != 1 || d !== 32'h0) begin n_fail++; $display("FAIL bus_unmapped_rd: ack %b lat %0d data %h want 1/1/0", ok, lat, d); end
    wb_access(ra(8'h20), 1'b1, 32'hFFFF_FFFF, 4'hF, d, ok, lat);
    wb_rd(8'h20, d, ok);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL bus_unmapped_wr: got %h want 0", d); end
    wb_access(32'h3000_0100, 1'b0, '0, 4'hF, d, ok, lat);
    n_chk++; if (ok !== 1'b0) begin n_fail++; $display("FAIL bus_out_of_range: ack %b want 0", ok); end
    wb_access(ra(OFS_ENABLE), 1'b1, 32'hFFFF_FFFF, 4'b0001, d, ok, lat);
    wb_rd(OFS_ENABLE, d, ok);
    n_chk++; if (d !== 32'h0000_00FF) begin n_fail++; $display("FAIL bus_sel_enable: got %h want 000000ff", d); end
    wb_access(ra(OFS_ROUTE), 1'b1, 32'hFFFF_FFFF, 4'b0010, d, ok, lat);
    wb_rd(OFS_ROUTE, d, ok);
    n_chk++; if (d !== 32'h0000_FF00) begin n_fail++; $display("FAIL bus_sel_route: got %h want 0000ff00", d); end
    wb_wr(OFS_MODE, 32'hFFFF_FFFF);
    wb_rd(OFS_MODE, d, ok);
    n_chk++; if (d !== 32'h0000_00FF) begin n_fail++; $display("FAIL bus_upper_bits: got %h want 000000ff", d); end
`ifndef USER_IRQ_CTRL_COUNT_EN
    wb_rd(OFS_COUNT, d, ok);
    n_chk++; if (!ok || d !== 32'h0) begin n_fail++; $display("FAIL bus_count_unmapped: ack %b got %h want 0", ok, d); end
`endif
    // Held strobe: one ack, then low the following cycle.
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = ra(OFS_ENABLE);
    @(posedge clk); #1;
    n_chk++; if (bus.wbs_ack_o !== 1'b1) begin n_fail++; $display("FAIL bus_ack_first: got %b want 1", bus.wbs_ack_o); end
    @(posedge clk); #1;
    n_chk++; if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL bus_ack_single: got %b want 0", bus.wbs_ack_o); end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_route();
    logic [31:0] d; logic ok;
    do_reset();
    src = '0;
    wb_wr(OFS_ROUTE, 32'h3);
    wb_wr(OFS_MODE, 32'h1);
    wb_wr(OFS_ENABLE, 32'h1);
    src[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_chk++; if (irq !== 3'b000) begin n_fail++; $display("FAIL route_unrouted: got %b want 000", irq); end
    wb_rd(OFS_PENDING, d, ok);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL route_pending: got %h want 1", d); end
    wb_wr(OFS_ROUTE, 32'h1);
    @(posedge clk); #1;
    n_chk++; if (irq !== 3'b010) begin n_fail++; $display("FAIL route_reroute: got %b want 010", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic ok;
    do_reset();
    src = '0;
    wb_wr(OFS_ENABLE, 32'hFF);
    wb_wr(OFS_MODE, 32'h0F);
    wb_wr(OFS_ROUTE, 32'h1234);
    wb_wr(OFS_POLARITY, 32'h00);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = ra(OFS_ENABLE); bus.wbs_dat_i = 32'h55;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_chk++; if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack cycle %0d: got %b want 0", c, bus.wbs_ack_o); end
    end
    @(negedge clk);
    bus_idle();
    rst = 1'b0;
    n_chk++; if (irq !== 3'b000) begin n_fail++; $display("FAIL rstmid_irq: got %b want 000", irq); end
    wb_rd(OFS_ENABLE, d, ok);
    n_chk++; if (!ok || d !== 32'h0) begin n_fail++; $display("FAIL rstmid_enable: ack %b got %h want 0", ok, d); end
    wb_rd(OFS_MODE, d, ok);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_mode: got %h want 0", d); end
    wb_rd(OFS_ROUTE, d, ok);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_route: got %h want 0", d); end
    wb_rd(OFS_POLARITY, d, ok);
    n_chk++; if (d !== 32'hFF) begin n_fail++; $display("FAIL rstmid_pol: got %h want ff", d); end
  endtask

  task automatic test_random();
    logic [NSRC-1:0]   en, mode, pol, pend_m, lvl, prv, rise;
    logic [2*NSRC-1:0] route;
    logic [NIRQ-1:0]   irq_m;
    logic [NSRC-1:0]   h [4];
    logic [31:0]       d;
    logic              ok;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      src = '0;
      en = NSRC'($urandom); mode = NSRC'($urandom); pol = NSRC'($urandom);
      route = (2*NSRC)'($urandom);
      wb_wr(OFS_POLARITY, 32'(pol));
      wb_wr(OFS_MODE, 32'(mode));
      wb_wr(OFS_ROUTE, 32'(route));
      wb_wr(OFS_ENABLE, 32'(en));
      repeat (6) @(negedge clk);
      // Inputs idle at 0 since reset: only active-low level sources are pending.
      pend_m = en & ~mode & ~pol;
      irq_m  = irq_of(pend_m, en, route);
      for (int k = 0; k < 4; k++) h[k] = '0;
      for (int c = 0; c < 84; c++) begin
        @(negedge clk);
        if (c < 80 && $urandom_range(0, 2) == 0) src = NSRC'($urandom);
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = src;
        @(posedge clk);
        // Input seen two edges ago is the one that reaches pending now.
        lvl   = ~(h[2] ^ pol);
        prv   = ~(h[3] ^ pol);
        rise  = lvl & ~prv;
        irq_m = irq_of(pend_m, en, route);
        for (int i = 0; i < int'(NSRC); i++) begin
          if (mode[i]) pend_m[i] = pend_m[i] | (rise[i] & en[i]);
          else         pend_m[i] = lvl[i] & en[i];
        end
        #1;
        n_chk++; if (irq !== irq_m) begin n_fail++; $display("FAIL rand_irq it %0d cyc %0d: got %b want %b", it, c, irq, irq_m); end
      end
      wb_rd(OFS_PENDING, d, ok);
      n_chk++; if (d !== 32'(pend_m)) begin n_fail++; $display("FAIL rand_pending it %0d: got %h want %h", it, d, 32'(pend_m)); end
    end
  endtask

`ifdef USER_IRQ_CTRL_COUNT_EN
  task automatic test_count();
    logic [31:0] d; logic ok;
    do_reset();
    src = '0;
    wb_wr(OFS_ENABLE, 32'h1);
    for (int p = 0; p < 5; p++) begin
      src[0] = 1'b1; repeat (4) @(negedge clk);
      src[0] = 1'b0; repeat (4) @(negedge clk);
    end
    wb_rd(OFS_COUNT, d, ok);
    n_chk++; if (d !== 32'd5) begin n_fail++; $display("FAIL count_five: got %0d want 5", d); end
    wb_wr(OFS_COUNT, 32'h0);
    wb_rd(OFS_COUNT, d, ok);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL count_clear: got %0d want 0", d); end
  endtask
`endif

  initial begin
    bus_idle();
    test_reset();
    test_edge();
    test_level();
    test_collision();
    test_bus();
    test_route();
    test_reset_mid();
    test_random();
`ifdef USER_IRQ_CTRL_COUNT_EN
    test_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/user_irq_ctrl.md
USER_IRQ_CTRL -- requirements
Module: user_irq_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- NSRC, 8: number of interrupt sources (1..16).
- NIRQ, 3: number of irq_o lines (1..3).
- BASE_ADR, 32'h3000_0000: Wishbone base address; decode on adr[31:8].
REQ-002 SHALL have ports, one per line:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lanes.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- src_i  in  NSRC  asynchronous interrupt sources.
- irq_o  out  NIRQ  interrupt lines to the management core.

Function
REQ-003 SHALL expose these registers, bit i = source i:
- 0x00 ENABLE (RW).
- 0x04 MODE (RW): 1=edge, 0=level.
- 0x08 POLARITY (RW): 1=rising/high, 0=falling/low.
- 0x0C PENDING: read returns pending; write-1-to-clear.
- 0x10 ROUTE (RW): 2 bits per source, bits [2i+1:2i]; a value >= NIRQ means unrouted.
REQ-004 SHALL synchronise each src_i bit through two flops before any use.
REQ-005 SHALL, in edge mode, set pending[i] on a synchronised polarity-qualified edge while ENABLE[i]=1; edges while disabled are lost.
REQ-006 SHALL, in level mode, make pending[i] track the synchronised polarity-qualified level ANDed with ENABLE[i]; W1C has no lasting effect in level mode.
REQ-007 SHALL give set priority over clear when an edge and a W1C hit the same bit in the same cycle (pending stays 1).
REQ-008 SHALL drive irq_o[k] from a register: OR over i of (pending[i] & ENABLE[i] & ROUTE[i]==k).
REQ-009 SHALL have fixed latency: irq_o rises on the 4th rising edge, counting the edge that first samples the new src_i value (sync1, sync2, pending, irq_o).
REQ-010 SHALL acknowledge a Wishbone access with wbs_ack_o high for exactly one cycle, the cycle after cyc&stb&address match; ack SHALL be low in the following cycle even if stb stays high.
REQ-011 SHALL not ack accesses outside BASE_ADR[31:8].
REQ-012 SHALL, for unmapped offsets inside the block, ack, read 0 and ignore writes.
REQ-013 SHALL apply writes per byte lane from wbs_sel_i.
REQ-014 SHALL read unused upper bits (i >= NSRC) as 0 and ignore writes to them.
REQ-015 SHALL take effect of a write on the edge that asserts ack; the new value SHALL affect pending/irq_o from the next cycle.

Reset
REQ-016 SHALL, while wb_rst_i=1 at a clock edge, clear ENABLE, MODE, PENDING, ROUTE, the synchronisers, irq_o, wbs_ack_o and wbs_dat_o to 0, and set POLARITY to all-ones.
REQ-017 SHALL abandon a bus access in flight at reset with no ack; the first access after reset deasserts SHALL behave normally.

Configuration
REQ-018 SHALL, with USER_IRQ_CTRL_COUNT_EN defined, add 0x14 COUNT: a 16-bit counter of pending 0->1 transitions, saturating at 16'hFFFF, cleared by any write.
REQ-019 SHALL, without USER_IRQ_CTRL_COUNT_EN, omit the counter logic and treat 0x14 as unmapped.

Structure
REQ-020 SHALL place register offsets, the ROUTE field width and the reset constants in package user_irq_ctrl_pkg.
REQ-021 SHALL implement the per-source two-flop synchroniser, polarity qualification and edge detect in sub-module irq_sync_edge, instantiated NSRC times.

Verification
REQ-022 Edge: ENABLE=0x01, MODE=0x01, ROUTE=0 -> src_i[0] 0->1 -> irq_o=3'b001 on the 4th edge, PENDING=0x01; write 0x0C=0x01 -> irq_o=0 two cycles later.
REQ-023 Level, active-low: ENABLE=0x80, POLARITY=0x7F, ROUTE[15:14]=2 -> src_i[7]=0 gives irq_o=3'b100; src_i[7]=1 clears it with no software action.
REQ-024 Collision: edge and W1C on bit 3 in the same cycle -> PENDING[3]=1 and irq_o held.
REQ-025 Bus: read 0x20 -> ack after 1 cycle, data 0; access to 0x3000_0100 -> no ack within 16 cycles; write sel=4'b0001 of 0xFFFF_FFFF to ENABLE -> reads 0x0000_00FF.
REQ-026 Routing/reset: ROUTE=2'b11 on source 0 -> no irq_o; reset asserted mid-access -> ack never issued, registers at reset values.
REQ-027 With USER_IRQ_CTRL_COUNT_EN: 5 edges on source 0 -> COUNT=5; write to 0x14 -> COUNT=0.
